// File: rtl/inference_port_filter.sv
// -----------------------------------------------------------------------------
// inference_port_filter
//
// Purpose: passes through only IPv4 / UDP packets addressed to MATCH_PORT
// (the inference traffic port). Every other packet is consumed and discarded.
// The decision needs two beats: the Ethernet/IPv4 header sits in beat 0 and the
// UDP destination port sits in beat 1. Beat 0 is therefore held back until
// beat 1 arrives. The whole packet is then either forwarded unmodified or dropped.
//
// Ports:
//   axis_aclk, axis_resetn    clock, asynchronous active-low reset
//   packet_in_axis_*          upstream AXI-Stream slave (tdata/tkeep/tuser/
//                             tvalid/tlast in, tready out)
//   packet_out_axis_*         downstream AXI-Stream master (registered)
//   pass_count, drop_count    wrapping per-packet counters
//   state_dbg                 current FSM state (HDR0=0 HDR1=1 PASS=2
//                             DRAIN=3 DROP=4)
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are both
// high. A master holds tvalid and its payload stable until that edge. tready
// never depends on tvalid. Byte i of tdata is tdata[8i+7:8i], and multi-byte
// fields are big-endian across ascending byte indices.
// -----------------------------------------------------------------------------
module inference_port_filter #(
  parameter int          TDATA_WIDTH = 256,
  parameter int          TUSER_WIDTH = 128,
  parameter logic [15:0] MATCH_PORT  = 16'h1F90,
  localparam int         TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                   axis_aclk,
  input  logic                   axis_resetn,

  input  logic [TDATA_WIDTH-1:0] packet_in_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0] packet_in_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0] packet_in_axis_tuser,
  input  logic                   packet_in_axis_tvalid,
  input  logic                   packet_in_axis_tlast,
  output logic                   packet_in_axis_tready,

  output logic [TDATA_WIDTH-1:0] packet_out_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] packet_out_axis_tkeep,
  output logic [TUSER_WIDTH-1:0] packet_out_axis_tuser,
  output logic                   packet_out_axis_tvalid,
  output logic                   packet_out_axis_tlast,
  input  logic                   packet_out_axis_tready,

  output logic [31:0]            pass_count,
  output logic [31:0]            drop_count,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    PASS  = 3'd2,
    DRAIN = 3'd3,
    DROP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [TKEEP_WIDTH-1:0] keep;
    logic [TUSER_WIDTH-1:0] user;
    logic                   last;
  } beat_t;

  function automatic logic [7:0] byte_of(input logic [TDATA_WIDTH-1:0] d,
                                         input int unsigned idx);
    return d[8*idx +: 8];
  endfunction

  state_t      state;
  beat_t       in_beat;
  beat_t       out_beat;
  beat_t       hold_beat;
  logic        out_valid;
  logic        hold_valid;
  logic        hdr_ok;
  logic [31:0] pass_cnt;
  logic [31:0] drop_cnt;

  logic        ready_c;
  logic        in_fire;
  logic        out_fire;
  logic        beat0_ok;
  logic        beat1_ok;

  assign in_beat = {packet_in_axis_tdata, packet_in_axis_tkeep,
                    packet_in_axis_tuser, packet_in_axis_tlast};

  // Beat 0 must be IPv4 with a 20-byte header (0x45), carry UDP, and not be
  // the last beat of the packet. tuser plays no part in the decision.
  assign beat0_ok = (byte_of(in_beat.data, 12) == 8'h08) &&
                    (byte_of(in_beat.data, 13) == 8'h00) &&
                    (byte_of(in_beat.data, 14) == 8'h45) &&
                    (byte_of(in_beat.data, 23) == 8'h11) &&
                    !in_beat.last;

  // The UDP destination port occupies bytes 4..5 of beat 1. Both bytes must be valid.
  assign beat1_ok = (in_beat.keep[5:4] == 2'b11) &&
                    ({byte_of(in_beat.data, 4), byte_of(in_beat.data, 5)} == MATCH_PORT);

  always_comb begin
    ready_c = 1'b0;
    unique case (state)
      HDR0:    ready_c = !out_valid && !hold_valid;
      HDR1:    ready_c = 1'b1;
      PASS:    ready_c = !hold_valid;
      DRAIN:   ready_c = 1'b0;
      DROP:    ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  // tready is forced low while reset is asserted, even though HDR0 with both
  // slots empty would otherwise advertise readiness.
  assign packet_in_axis_tready = axis_resetn & ready_c;
  assign in_fire  = packet_in_axis_tvalid & packet_in_axis_tready;
  assign out_fire = out_valid & packet_out_axis_tready;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= HDR0;
      out_beat   <= '0;
      hold_beat  <= '0;
      out_valid  <= 1'b0;
      hold_valid <= 1'b0;
      hdr_ok     <= 1'b0;
      pass_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      unique case (state)
        HDR0: begin
          if (in_fire) begin
            hold_beat <= in_beat;
            hdr_ok    <= beat0_ok;
            if (in_beat.last) begin
              hold_valid <= 1'b0;
              drop_cnt   <= drop_cnt + 32'd1;
            end else begin
              hold_valid <= 1'b1;
              state      <= HDR1;
            end
          end
        end

        HDR1: begin
          if (in_fire) begin
            if (hdr_ok && beat1_ok) begin
              // OUT is guaranteed empty here because HDR0 only accepts with both slots free.
              out_beat   <= hold_beat;
              out_valid  <= 1'b1;
              hold_beat  <= in_beat;
              hold_valid <= 1'b1;
              pass_cnt   <= pass_cnt + 32'd1;
              state      <= in_beat.last ? DRAIN : PASS;
            end else begin
              hold_valid <= 1'b0;
              drop_cnt   <= drop_cnt + 32'd1;
              state      <= in_beat.last ? HDR0 : DROP;
            end
          end
        end

        PASS, DRAIN: begin
          // Two-entry skid. OUT refills from HOLD first, then straight from the input.
          // An input beat arrives only while HOLD is empty, because tready is
          // !hold_valid in PASS and low in DRAIN.
          if (out_fire || !out_valid) begin
            if (hold_valid) begin
              out_beat   <= hold_beat;
              out_valid  <= 1'b1;
              hold_valid <= 1'b0;
            end else if (in_fire) begin
              out_beat  <= in_beat;
              out_valid <= 1'b1;
            end else begin
              out_valid <= 1'b0;
            end
          end else if (in_fire) begin
            hold_beat  <= in_beat;
            hold_valid <= 1'b1;
          end

          if (state == PASS) begin
            if (in_fire && in_beat.last) state <= DRAIN;
          end else if (!out_valid && !hold_valid) begin
            state <= HDR0;
          end
        end

        DROP: begin
          if (in_fire && in_beat.last) state <= HDR0;
        end

        default: state <= HDR0;
      endcase
    end
  end

  assign packet_out_axis_tdata  = out_beat.data;
  assign packet_out_axis_tkeep  = out_beat.keep;
  assign packet_out_axis_tuser  = out_beat.user;
  assign packet_out_axis_tlast  = out_beat.last;
  assign packet_out_axis_tvalid = out_valid;
  assign pass_count             = pass_cnt;
  assign drop_count             = drop_cnt;
  assign state_dbg              = state;

endmodule

// File: tb/tb_inference_port_filter.sv
// -----------------------------------------------------------------------------
// tb_inference_port_filter
//
// Purpose: directed self-checking bench for inference_port_filter. The bench
// builds packets, pushes the beats expected downstream into exp_q, drives them
// upstream and compares every downstream handshake against the queue. It also
// checks counters, latency, stall stability, counter wrap and reset behaviour.
// -----------------------------------------------------------------------------
module tb_inference_port_filter;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;
  localparam int BW = 1 + KW + UW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [DW-1:0] in_tdata;
  logic [KW-1:0] in_tkeep;
  logic [UW-1:0] in_tuser;
  logic          in_tvalid;
  logic          in_tlast;
  logic          in_tready;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic [UW-1:0] out_tuser;
  logic          out_tvalid;
  logic          out_tlast;
  logic          out_tready;
  logic [31:0]   pass_count;
  logic [31:0]   drop_count;
  logic [2:0]    dbg;

  inference_port_filter dut (
    .axis_aclk              (clk),
    .axis_resetn            (rst_n),
    .packet_in_axis_tdata   (in_tdata),
    .packet_in_axis_tkeep   (in_tkeep),
    .packet_in_axis_tuser   (in_tuser),
    .packet_in_axis_tvalid  (in_tvalid),
    .packet_in_axis_tlast   (in_tlast),
    .packet_in_axis_tready  (in_tready),
    .packet_out_axis_tdata  (out_tdata),
    .packet_out_axis_tkeep  (out_tkeep),
    .packet_out_axis_tuser  (out_tuser),
    .packet_out_axis_tvalid (out_tvalid),
    .packet_out_axis_tlast  (out_tlast),
    .packet_out_axis_tready (out_tready),
    .pass_count             (pass_count),
    .drop_count             (drop_count),
    .state_dbg              (dbg)
  );

  int pass_n  = 0;
  int total_n = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- packet building ----------------
  logic [BW-1:0] pkt[$];
  logic [BW-1:0] exp_q[$];

  function automatic logic [BW-1:0] pk(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                       input logic [UW-1:0] u, input logic l);
    return {l, k, u, d};
  endfunction

  function automatic logic [DW-1:0] fill(input logic [7:0] seed);
    logic [DW-1:0] d;
    for (int i = 0; i < 32; i++) d[8*i +: 8] = seed + 8'(i * 3);
    return d;
  endfunction

  // Builds an n-beat packet. The header fields are configurable so that each
  // drop condition can be exercised on its own.
  task automatic make_pkt(input logic [15:0] etype, input logic [7:0] vihl,
                          input logic [7:0] proto, input logic [15:0] port,
                          input logic [KW-1:0] keep1, input int n, input logic [7:0] seed);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    pkt.delete();
    for (int b = 0; b < n; b++) begin
      d = fill(seed + 8'(b * 17));
      k = '1;
      if (b == 0) begin
        d[8*12 +: 8] = etype[15:8];
        d[8*13 +: 8] = etype[7:0];
        d[8*14 +: 8] = vihl;
        d[8*23 +: 8] = proto;
      end
      if (b == 1) begin
        d[8*4 +: 8] = port[15:8];
        d[8*5 +: 8] = port[7:0];
        k = keep1;
      end
      if (b == n - 1 && b > 1) k = 32'h0000_FFFF;
      pkt.push_back(pk(d, k, {4{24'hABCDEF, 8'(seed + 8'(b))}}, (b == n - 1)));
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [BW-1:0] b, output int waits);
    waits = 0;
    @(negedge clk);
    {in_tlast, in_tkeep, in_tuser, in_tdata} = b;
    in_tvalid = 1'b1;
    while (!in_tready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_tready) check("send_timeout", in_tready, 1'b1);
    @(posedge clk);
    #1 in_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input bit expect_pass, output int wsum2);
    int w;
    wsum2 = 0;
    if (expect_pass) foreach (pkt[i]) exp_q.push_back(pkt[i]);
    foreach (pkt[i]) begin
      send(pkt[i], w);
      if (i < 2) wsum2 += w;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || dbg != 3'd0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(tag, {exp_q.size(), dbg}, {32'd0, 3'd0});
  endtask

  // ---------------- scoreboard monitor ----------------
  logic          stalled = 1'b0;
  logic [BW-1:0] last_b;
  logic [BW-1:0] cur;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      cur = {out_tlast, out_tkeep, out_tuser, out_tdata};
      if (stalled) check("stall_hold", {out_tvalid, cur}, {1'b1, last_b});
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", out_tvalid, 1'b0);
        else check("out_beat", cur, exp_q.pop_front());
      end
      stalled = out_tvalid && !out_tready;
      last_b  = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [3:0] pat = 4'b1001;

  initial begin
    int w, w2;
    rst_n = 1'b0;
    in_tvalid = 1'b0;
    in_tdata = '0;
    in_tkeep = '0;
    in_tuser = '0;
    in_tlast = 1'b0;
    out_tready = 1'b1;

    // Reset state
    #3;
    check("reset_ready", in_tready, 1'b0);
    check("reset_outs", {out_tvalid, out_tlast, out_tkeep, out_tdata}, '0);
    check("reset_cnts", {pass_count, drop_count, dbg}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 3-beat matching packet: first beat out the cycle after beat 1 is accepted
    make_pkt(16'h0800, 8'h45, 8'h11, 16'h1F90, '1, 3, 8'h10);
    foreach (pkt[i]) exp_q.push_back(pkt[i]);
    send(pkt[0], w);
    send(pkt[1], w);
    @(negedge clk);
    #1 check("first_latency", {out_tvalid, out_tdata}, {1'b1, pkt[0][DW-1:0]});
    send(pkt[2], w);
    wait_idle("idle_pass3");
    check("cnt_pass3", {pass_count, drop_count}, {32'd1, 32'd0});

    // Wrong port: dropped with tready held high throughout
    make_pkt(16'h0800, 8'h45, 8'h11, 16'h1F91, '1, 3, 8'h20);
    w2 = 0;
    foreach (pkt[i]) begin
      send(pkt[i], w);
      w2 += w;
    end
    wait_idle("idle_port");
    check("drop_ready", w2, 0);
    check("cnt_port", {pass_count, drop_count}, {32'd1, 32'd1});

    // ARP then a matching packet, back to back
    make_pkt(16'h0806, 8'h45, 8'h11, 16'h1F90, '1, 2, 8'h30);
    send_pkt(1'b0, w);
    make_pkt(16'h0800, 8'h45, 8'h11, 16'h1F90, '1, 3, 8'h40);
    send_pkt(1'b1, w2);
    check("b2b_ready", w + w2, 0);
    wait_idle("idle_arp");
    check("cnt_arp", {pass_count, drop_count}, {32'd2, 32'd2});

    // Single-beat frame with tlast on beat 0
    make_pkt(16'h0800, 8'h45, 8'h11, 16'h1F90, '1, 1, 8'h50);
    send(pkt[0], w);
    @(negedge clk);
    #1 check("single_hdr0", {dbg, in_tready}, {3'd0, 1'b1});
    check("cnt_single", {pass_count, drop_count}, {32'd2, 32'd3});

    // Each remaining drop condition on its own
    make_pkt(16'h0800, 8'h45, 8'h11, 16'h1F90, 32'hFFFF_FFDF, 3, 8'h60);
    send_pkt(1'b0, w);
    make_pkt(16'h0800, 8'h45, 8'h06, 16'h1F90, '1, 3, 8'h70);
    send_pkt(1'b0, w);
    make_pkt(16'h0800, 8'h46, 8'h11, 16'h1F90, '1, 2, 8'h80);
    send_pkt(1'b0, w);
    wait_idle("idle_neg");
    check("cnt_neg", {pass_count, drop_count}, {32'd2, 32'd6});

    // 6-beat matching packet with out_tready cycling 1,0,0,1
    make_pkt(16'h0800, 8'h45, 8'h11, 16'h1F90, '1, 6, 8'h90);
    fork
      send_pkt(1'b1, w);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        out_tready = pat[i % 4];
      end
    join
    out_tready = 1'b1;
    wait_idle("idle_stall");
    check("cnt_stall", {pass_count, drop_count}, {32'd3, 32'd6});

    // drop_count wrap
    @(negedge clk);
    force dut.drop_cnt = 32'hFFFF_FFFF;
    #1 release dut.drop_cnt;
    @(negedge clk);
    check("cnt_preset", drop_count, 32'hFFFF_FFFF);
    make_pkt(16'h0806, 8'h45, 8'h11, 16'h1F90, '1, 2, 8'hA0);
    send_pkt(1'b0, w);
    wait_idle("idle_wrap");
    check("cnt_wrap", {pass_count, drop_count}, {32'd3, 32'd0});

    // Reset in the middle of PASS
    out_tready = 1'b0;
    make_pkt(16'h0800, 8'h45, 8'h11, 16'h1F90, '1, 6, 8'hB0);
    send(pkt[0], w);
    send(pkt[1], w);
    @(negedge clk);
    check("mid_pass_state", {dbg, out_tvalid}, {3'd2, 1'b1});
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_outs", {out_tvalid, out_tlast, out_tkeep, out_tuser, out_tdata}, '0);
    check("rst_cnts", {pass_count, drop_count, dbg, in_tready}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_tready = 1'b1;

    // First packet after reset release is parsed from its beat 0
    make_pkt(16'h0800, 8'h45, 8'h11, 16'h1F90, '1, 2, 8'hC0);
    send_pkt(1'b1, w);
    wait_idle("idle_post_rst");
    check("cnt_post_rst", {pass_count, drop_count}, {32'd1, 32'd0});

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/inference_port_filter.md
INFERENCE_PORT_FILTER -- requirements
Module: inference_port_filter

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 256, AXIS data width; 256 is the only supported value.
REQ-002 SHALL have parameter TUSER_WIDTH, default 128, AXIS sideband width.
REQ-003 SHALL have parameter MATCH_PORT, default 16'h1F90, UDP destination port of inference traffic.
REQ-004 SHALL have derived localparam TKEEP_WIDTH = TDATA_WIDTH/8.
REQ-005 axis_aclk  in  1  sole clock; all state changes on rising edge.
REQ-006 axis_resetn  in  1  reset, asynchronous, active-low.
REQ-007 packet_in_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  upstream AXIS beat.
REQ-008 packet_in_axis_tready  out  1  upstream accept.
REQ-009 packet_out_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  filtered AXIS beat, fed to packet_processor.
REQ-010 packet_out_axis_tready  in  1  downstream accept.
REQ-011 pass_count  out  32  packets forwarded.
REQ-012 drop_count  out  32  packets discarded.

Function
REQ-013 SHALL treat byte i as tdata[8i+7:8i]; multi-byte fields are big-endian across ascending byte indices.
REQ-014 SHALL forward a packet unmodified (data, keep, user, last) only if: beat0 EtherType {b12,b13}==16'h0800, b14==8'h45, protocol b23==8'h11, beat0 tlast=0, beat1 tkeep[5:4]==2'b11, and beat1 dest port {b4,b5}==MATCH_PORT; otherwise SHALL discard the whole packet.
REQ-015 SHALL implement states HDR0, HDR1, PASS, DRAIN, DROP; reset state HDR0.
REQ-016 Storage: two beat slots, OUT (drives packet_out_*) and HOLD; packet_out_axis_tvalid = OUT valid.
REQ-017 HDR0: tready=1 only when both slots empty; on handshake capture beat in HOLD, latch header-ok flag; tlast=1 -> drop_count+1, HOLD cleared, stay HDR0; else -> HDR1.
REQ-018 HDR1: tready=1; on handshake evaluate REQ-014. Pass: OUT<=HOLD (beat0), HOLD<=beat1, pass_count+1, -> DRAIN if beat1 tlast else PASS. Fail: HOLD cleared, drop_count+1, -> HDR0 if beat1 tlast else DROP.
REQ-019 PASS: tready = !HOLD valid; output handshake moves HOLD to OUT (or empties OUT); accepted input goes to OUT if OUT empty or firing with HOLD empty, else HOLD; accepting tlast -> DRAIN.
REQ-020 DRAIN: tready=0; when both slots empty -> HDR0 (next cycle may accept).
REQ-021 DROP: tready=1, beats discarded; accepting tlast -> HDR0.
REQ-022 Output beat SHALL hold stable while tvalid=1 and tready=0; no combinational path packet_in_* -> packet_out_*.
REQ-023 Latency: first forwarded beat valid the cycle after beat1 accepted; steady state one beat per cycle until end of packet.
REQ-024 Counters SHALL increment once per packet at decision time and wrap 32'hFFFFFFFF -> 0.
REQ-025 tuser of forwarded beats SHALL be passed unchanged; filter decision SHALL ignore tuser.

Reset
REQ-026 On axis_resetn low, asynchronously: state HDR0, both slots invalid, packet_out_axis_tvalid=0, packet_out_axis_tdata/tkeep/tuser/tlast=0, pass_count=0, drop_count=0, packet_in_axis_tready=0 while reset asserted.
REQ-027 Reset mid-packet SHALL abandon the packet without counting it; first beat after release is treated as beat0.

Verification
REQ-028 3-beat UDP packet to port 0x1F90, out_tready=1 -> same 3 beats out, first one cycle after beat1 accepted, pass_count=1.
REQ-029 Same packet with port 0x1F91 -> no output beats, drop_count=1, tready=1 throughout.
REQ-030 ARP (EtherType 0x0806) 2-beat packet followed by matching packet back-to-back -> only second forwarded; pass_count=1, drop_count=1.
REQ-031 Single-beat 32-byte frame (tlast on beat0) -> dropped, drop_count=1, state HDR0 next cycle.
REQ-032 Matching 6-beat packet with out_tready toggling 1,0,0,1 -> all 6 beats in order, no loss/duplication, tdata stable while stalled.
REQ-033 drop_count preset to 32'hFFFFFFFF via 2^32 drops (or force) then one more drop -> 0; reset asserted mid-PASS -> outputs 0 immediately, counters 0.
